// File: rtl/pattern_seq_mem_if.sv
// Avalon-MM slave bus used by the CPU to reach the pattern RAM and sequencer registers.
interface pattern_seq_mem_if #(
  parameter int ADDR_W = 12
);
  logic              avl_read;
  logic              avl_write;
  logic              avl_cs;
  logic [3:0]        avl_byte_en;
  logic [ADDR_W-1:0] avl_addr;
  logic [31:0]       avl_writedata;
  logic [31:0]       avl_readdata;

  modport master (
    output avl_read, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata,
    input  avl_readdata
  );

  modport slave (
    input  avl_read, avl_write, avl_cs, avl_byte_en, avl_addr, avl_writedata,
    output avl_readdata
  );
endinterface

// File: rtl/pattern_seq_mem.sv
// Pattern RAM (CPU port A, engine port B) plus multi-track step sequencer.
// Define SEQ_SWING_EN to enable the SWING register (alternating long/short step periods).
module pattern_seq_mem #(
  parameter int NUM_TRACKS = 4,
  parameter int STEPS      = 32,
  parameter int ADDR_W     = 12,
  parameter int DIV_W      = 24,
  localparam int STEP_W    = $clog2(STEPS)
) (
  input  logic                  clk,
  input  logic                  rst,
  pattern_seq_mem_if.slave      avl,
  output logic [NUM_TRACKS-1:0] trig,
  output logic                  trig_stb,
  output logic [STEP_W-1:0]     step,
  output logic                  running
);

  localparam int RAM_AW     = ADDR_W - 1;
  localparam int RAM_WORDS  = 1 << RAM_AW;
  localparam int CNT_W      = DIV_W + 1;
  localparam int MIN_PERIOD = NUM_TRACKS + 2;

  typedef enum logic [1:0] {IDLE, FETCH, FIRE, WAIT} state_t;

  logic [31:0]           mem [RAM_WORDS];
  logic [31:0]           eng_word;
  logic [RAM_AW-1:0]     eng_addr;

  logic                  run;
  logic [DIV_W-1:0]      tempo;
  logic [RAM_AW-1:0]     bank;
  logic [RAM_AW-1:0]     bank_active;
`ifdef SEQ_SWING_EN
  logic [DIV_W-1:0]      swing;
  logic [DIV_W-1:0]      swing_eff;
`endif

  logic                  rd_en;
  logic                  wr_en;
  logic                  sel_reg;
  logic [2:0]            reg_idx;
  logic [RAM_AW-1:0]     ram_addr;
  logic [31:0]           reg_rdata;
  logic [31:0]           merged;
  logic                  unused_merged;

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      period;
  logic [DIV_W-1:0]      tempo_eff;
  logic [CNT_W-1:0]      period_even;
  logic [CNT_W-1:0]      period_odd;
  logic [NUM_TRACKS-1:0] trig_buf;
  logic [NUM_TRACKS-1:0] fetch_bits;
  logic [STEP_W-1:0]     step_next;
  logic                  wrap;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  assign rd_en    = avl.avl_read && avl.avl_cs;
  assign wr_en    = avl.avl_write && avl.avl_cs;
  assign sel_reg  = avl.avl_addr[ADDR_W-1];
  assign reg_idx  = avl.avl_addr[2:0];
  assign ram_addr = avl.avl_addr[RAM_AW-1:0];

  always_comb begin
    reg_rdata = '0;
    case (reg_idx)
      3'd0: reg_rdata[0]              = run;
      3'd1: reg_rdata[DIV_W-1:0]      = tempo;
      3'd2: reg_rdata[RAM_AW-1:0]     = bank;
      3'd3: reg_rdata[STEP_W:0]       = {running, step};
`ifdef SEQ_SWING_EN
      3'd4: reg_rdata[DIV_W-1:0]      = swing;
`endif
      default: reg_rdata = '0;
    endcase
  end

  // Register writes merge the new bytes into the current readback value.
  assign merged        = be_merge(reg_rdata, avl.avl_writedata, avl.avl_byte_en);
  assign unused_merged = ^merged[31:DIV_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run   <= 1'b0;
      tempo <= '0;
      bank  <= '0;
`ifdef SEQ_SWING_EN
      swing <= '0;
`endif
    end else if (wr_en && sel_reg) begin
      case (reg_idx)
        3'd0: run   <= merged[0];
        3'd1: tempo <= merged[DIV_W-1:0];
        3'd2: bank  <= merged[RAM_AW-1:0];
`ifdef SEQ_SWING_EN
        3'd4: swing <= merged[DIV_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  // Port B reads old data when port A writes the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (wr_en && !sel_reg) begin
      for (int b = 0; b < 4; b++)
        if (avl.avl_byte_en[b])
          mem[ram_addr][8*b +: 8] <= avl.avl_writedata[8*b +: 8];
    end
    eng_word <= mem[eng_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      avl.avl_readdata <= '0;
    else if (rd_en)
      avl.avl_readdata <= sel_reg ? reg_rdata : mem[ram_addr];
  end

  assign eng_addr = RAM_AW'(32'(bank_active) * 32'(NUM_TRACKS) + 32'(cnt));

  always_comb begin
    tempo_eff = (tempo < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD) : tempo;
`ifdef SEQ_SWING_EN
    swing_eff = (swing < tempo_eff - DIV_W'(MIN_PERIOD)) ? swing
                                                          : tempo_eff - DIV_W'(MIN_PERIOD);
    period_even = {1'b0, tempo_eff} + {1'b0, swing_eff};
    period_odd  = {1'b0, tempo_eff - swing_eff};
`else
    period_even = {1'b0, tempo_eff};
    period_odd  = {1'b0, tempo_eff};
`endif
  end

  assign wrap      = (step == STEP_W'(STEPS - 1));
  assign step_next = wrap ? '0 : step + 1'b1;

  // Word t arrives one cycle after its read, i.e. while cnt == t+1.
  always_comb begin
    fetch_bits = trig_buf;
    for (int t = 0; t < NUM_TRACKS; t++)
      if (cnt == CNT_W'(t + 1))
        fetch_bits[t] = eng_word[step];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      period      <= '0;
      trig_buf    <= '0;
      trig        <= '0;
      trig_stb    <= 1'b0;
      step        <= '0;
      running     <= 1'b0;
      bank_active <= '0;
    end else if (!run) begin
      state    <= IDLE;
      cnt      <= '0;
      trig     <= '0;
      trig_stb <= 1'b0;
      step     <= '0;
      running  <= 1'b0;
    end else begin
      trig_stb <= 1'b0;
      case (state)
        IDLE: begin
          state       <= FETCH;
          running     <= 1'b1;
          step        <= '0;
          bank_active <= bank;
          cnt         <= '0;
          period      <= period_even;
        end
        FETCH: begin
          cnt      <= cnt + 1'b1;
          trig_buf <= fetch_bits;
          if (cnt == CNT_W'(NUM_TRACKS)) begin
            state    <= FIRE;
            trig     <= fetch_bits;
            trig_stb <= 1'b1;
          end
        end
        // The period counter keeps running from FETCH entry, so a minimum
        // period can expire already in FIRE.
        FIRE, WAIT: begin
          if (cnt >= period - 1'b1) begin
            state  <= FETCH;
            cnt    <= '0;
            step   <= step_next;
            period <= step_next[0] ? period_odd : period_even;
            if (wrap)
              bank_active <= bank;
          end else begin
            state <= WAIT;
            cnt   <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_seq_mem.sv
// Randomized self-checking bench for pattern_seq_mem: bus map, byte enables, step timing and triggers.
`timescale 1ns/1ps
module tb_pattern_seq_mem;

  localparam int NT     = 4;
  localparam int STEPS  = 32;
  localparam int ADDR_W = 12;
  localparam int DIV_W  = 24;
  localparam int MINP   = NT + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NT-1:0] trig;
  logic          trig_stb;
  logic [4:0]    step;
  logic          running;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] memModel [2048];

  typedef struct {
    int            c;
    logic [NT-1:0] t;
    logic [4:0]    s;
  } stb_t;
  stb_t stbQ[$];

  pattern_seq_mem_if #(.ADDR_W(ADDR_W)) avl();

  pattern_seq_mem #(
    .NUM_TRACKS(NT), .STEPS(STEPS), .ADDR_W(ADDR_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst(rst), .avl(avl),
    .trig(trig), .trig_stb(trig_stb), .step(step), .running(running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log every strobe with the cycle it occurred in.
  always @(posedge clk) begin
    #1;
    if (trig_stb === 1'b1) stbQ.push_back('{c: cyc, t: trig, s: step});
  end

  initial begin
    #2_000_000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] beMerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  function automatic logic [ADDR_W-1:0] regAddr(input int idx);
    return 12'h800 + 12'(idx);
  endfunction

  function automatic logic [NT-1:0] expTrig(input int b, input int s);
    logic [NT-1:0] r;
    logic [31:0]   w;
    for (int t = 0; t < NT; t++) begin
      w    = memModel[(b * NT + t) % 2048];
      r[t] = w[s];
    end
    return r;
  endfunction

  task automatic waitUntil(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic avlWrite(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] be);
    avl.avl_cs = 1'b1; avl.avl_write = 1'b1; avl.avl_addr = a;
    avl.avl_writedata = d; avl.avl_byte_en = be;
    @(posedge clk); #1;
    avl.avl_cs = 1'b0; avl.avl_write = 1'b0;
  endtask

  task automatic avlRead(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    avl.avl_cs = 1'b1; avl.avl_read = 1'b1; avl.avl_addr = a;
    @(posedge clk); #1;
    avl.avl_cs = 1'b0; avl.avl_read = 1'b0;
    d = avl.avl_readdata;
  endtask

  task automatic ramWrite(input int a, input logic [31:0] d);
    avlWrite(12'(a), d, 4'hF);
    memModel[a] = d;
  endtask

  // Runs the sequencer and checks every strobe against the step-timing model.
  task automatic applyStimulus(input int tempoVal, input int swingVal, input int bankStart,
                               input int bankNew, input int nStrobes, input bit endWithReset);
    int fs[$];
    int tEff, sEff, w, r, k, nExp;
    logic [31:0] rd;
    tEff = (tempoVal < MINP) ? MINP : tempoVal;
`ifdef SEQ_SWING_EN
    sEff = (swingVal < tEff - MINP) ? swingVal : tEff - MINP;
`else
    sEff = 0;
`endif
    avlWrite(regAddr(1), 32'(tempoVal), 4'hF);
    avlWrite(regAddr(4), 32'(swingVal), 4'hF);
    avlWrite(regAddr(2), 32'(bankStart), 4'hF);
    stbQ.delete();
    w = cyc;
    avlWrite(regAddr(0), 32'd1, 4'hF);
    fs.push_back(w + 2);
    for (int j = 0; j < nStrobes + 2; j++)
      fs.push_back(fs[j] + (((j % 2) == 0) ? tEff + sEff : tEff - sEff));

    waitUntil(fs[5] + 1);
    avlWrite(regAddr(2), 32'(bankNew), 4'hF);
    avlWrite(regAddr(0), 32'd1, 4'hF);
    r = cyc;
    avlRead(regAddr(3), rd);
    k = 0;
    while (k + 1 < fs.size() && fs[k+1] <= r) k++;
    checkOutput("status_run", rd, {26'b0, 1'b1, 5'(k % STEPS)});

    if (!endWithReset) begin
      waitUntil(fs[nStrobes]);
      avlWrite(regAddr(0), 32'd0, 4'hF);
      @(posedge clk); #1;
      checkOutput("stop_running", 32'(running), 32'd0);
      checkOutput("stop_trig", 32'(trig), 32'd0);
      checkOutput("stop_step", 32'(step), 32'd0);
      checkOutput("stop_stb", 32'(trig_stb), 32'd0);
      repeat (20) @(posedge clk);
      #1;
      nExp = nStrobes;
    end else begin
      waitUntil(fs[nStrobes] + NT + 3);
      rst = 1'b1;
      #1;
      checkOutput("rst_running", 32'(running), 32'd0);
      checkOutput("rst_trig", 32'(trig), 32'd0);
      checkOutput("rst_step", 32'(step), 32'd0);
      checkOutput("rst_stb", 32'(trig_stb), 32'd0);
      checkOutput("rst_rdata", avl.avl_readdata, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      nExp = nStrobes + 1;
    end

    checkOutput("stb_count", 32'(stbQ.size()), 32'(nExp));
    for (int j = 0; j < nExp && j < stbQ.size(); j++) begin
      checkOutput("stb_cycle", 32'(stbQ[j].c), 32'(fs[j] + NT + 1));
      checkOutput("stb_step", 32'(stbQ[j].s), 32'(j % STEPS));
      checkOutput("stb_trig", 32'(stbQ[j].t),
                  32'(expTrig((j >= STEPS) ? bankNew : bankStart, j % STEPS)));
    end
  endtask

  initial begin
    logic [31:0] rd, d, expv;
    logic [3:0]  be;
    int a, bankB;

    rst = 1'b1;
    avl.avl_read = 1'b0; avl.avl_write = 1'b0; avl.avl_cs = 1'b0;
    avl.avl_byte_en = 4'h0; avl.avl_addr = '0; avl.avl_writedata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_trig", 32'(trig), 32'd0);
    checkOutput("reset_stb", 32'(trig_stb), 32'd0);
    checkOutput("reset_step", 32'(step), 32'd0);
    checkOutput("reset_running", 32'(running), 32'd0);
    checkOutput("reset_rdata", avl.avl_readdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    ramWrite(5, 32'hA5A5_A5A5);
    avlRead(12'h005, rd);
    checkOutput("ram_full", rd, 32'hA5A5_A5A5);
    avlWrite(12'h005, 32'h0000_3C00, 4'h2);
    memModel[5] = beMerge(memModel[5], 32'h0000_3C00, 4'h2);
    avlRead(12'h005, rd);
    checkOutput("ram_be", rd, 32'hA5A5_3CA5);
    ramWrite(2047, 32'h1234_5678);
    checkOutput("rd_hold", avl.avl_readdata, 32'hA5A5_3CA5);
    avlRead(12'h7FF, rd);
    checkOutput("ram_top", rd, 32'h1234_5678);

    for (int i = 0; i < 16; i++) ramWrite(i, $urandom);
    for (int i = 0; i < 10; i++) begin
      a  = $urandom_range(0, 15);
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      avlWrite(12'(a), d, be);
      memModel[a] = beMerge(memModel[a], d, be);
    end
    for (int i = 0; i < 16; i++) begin
      avlRead(12'(i), rd);
      checkOutput("ram_rand", rd, memModel[i]);
    end

    d = $urandom;
    avlWrite(regAddr(1), d, 4'hF);
    expv = d & 32'h00FF_FFFF;
    d = $urandom;
    avlWrite(regAddr(1), d, 4'b0101);
    expv = beMerge(expv, d, 4'b0101) & 32'h00FF_FFFF;
    avlRead(regAddr(1), rd);
    checkOutput("reg_tempo", rd, expv);
    d = $urandom;
    avlWrite(regAddr(2), d, 4'hF);
    avlRead(regAddr(2), rd);
    checkOutput("reg_bank", rd, d & 32'h0000_07FF);
    d = $urandom;
    avlWrite(regAddr(4), d, 4'hF);
    avlRead(regAddr(4), rd);
`ifdef SEQ_SWING_EN
    checkOutput("reg_swing", rd, d & 32'h00FF_FFFF);
`else
    checkOutput("reg_swing", rd, 32'd0);
`endif
    for (int i = 5; i < 8; i++) begin
      avlWrite(regAddr(i), $urandom, 4'hF);
      avlRead(regAddr(i), rd);
      checkOutput("reg_unmapped", rd, 32'd0);
    end
    avlRead(regAddr(3), rd);
    checkOutput("status_idle", rd, 32'd0);
    avlRead(regAddr(0), rd);
    checkOutput("reg_ctrl", rd, 32'd0);

    // Bank 0 is the one-hot walking pattern, bank 1 random; tempo clamps to the minimum.
    ramWrite(0, 32'd1); ramWrite(1, 32'd2); ramWrite(2, 32'd4); ramWrite(3, 32'd8);
    for (int i = 4; i < 8; i++) ramWrite(i, $urandom);
    applyStimulus($urandom_range(0, 5), 0, 0, 1, 40, 1'b0);

`ifdef SEQ_SWING_EN
    applyStimulus(20, 4, 1, 1, 8, 1'b0);
    applyStimulus(20, 50, 0, 0, 8, 1'b0);
    applyStimulus($urandom_range(8, 30), $urandom_range(0, 30), 1, 0, 8, 1'b0);
`endif

    bankB = $urandom_range(2, 500);
    for (int t = 0; t < NT; t++) ramWrite(bankB * NT + t, $urandom);
    applyStimulus($urandom_range(10, 15), $urandom_range(0, 6), bankB, bankB,
                  2 * $urandom_range(3, 7), 1'b1);

    avlRead(regAddr(1), rd);
    checkOutput("post_rst_tempo", rd, 32'd0);
    avlRead(regAddr(0), rd);
    checkOutput("post_rst_ctrl", rd, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_running", 32'(running), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
